id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of the pc, register-data, immediate and shamt fields.
REQ-002 Payload P is (5*WIDTH+25) bits, MSB first: pc, rs_data, rt_data, imm_ext, shamt_ext (each WIDTH), rs, rt, rd (5 each), ctrl (10).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  ID stage presents a decoded instruction.
REQ-006 in_ready  output  1  block accepts a payload this cycle.
REQ-007 in_payload  input  5*WIDTH+25  payload P; imm_ext is the 16-bit extender output, shamt_ext is the 5-bit extender output.
REQ-008 flush  input  1  discard all held and incoming entries (branch/jump redirect).
REQ-009 out_valid  output  1  EX stage payload valid.
REQ-010 out_ready  input  1  EX stage consumes the payload this cycle.
REQ-011 out_payload  output  5*WIDTH+25  payload P to the EX stage.
REQ-012 stall_cnt  output  16  cycles spent with out_valid=1 and out_ready=0.

Function
REQ-013 Block SHALL be a 2-entry in-order buffer: main entry drives out_payload; skid entry absorbs one payload when EX stalls.
REQ-014 State SHALL be one of EMPTY (0 entries), ONE (main only), FULL (main+skid).
REQ-015 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-016 in_ready SHALL be a registered output equal to 1 in EMPTY and ONE, 0 in FULL.
REQ-017 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-018 EMPTY: accept -> ONE, payload loaded into main; out_valid rises the next cycle (latency 1).
REQ-019 ONE: accept & pop -> ONE, main replaced by new payload; pop only -> EMPTY; accept only -> FULL, payload into skid.
REQ-020 FULL: pop -> ONE, skid moved to main; no pop -> FULL, contents held unchanged.
REQ-021 Sustained in_valid=1, out_ready=1 SHALL give one payload per cycle with no bubbles.
REQ-022 Payloads SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-023 flush=1 SHALL move to EMPTY on the next edge regardless of accept/pop in the same cycle; the incoming payload that cycle is discarded.
REQ-024 When out_valid=0 the ctrl field of out_payload SHALL be 0 (bubble: no RegWrite/MemRead/MemWrite reaches EX); other fields are don't-care.
REQ-025 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturate at 16'hFFFF, be unaffected by flush.
REQ-026 Payload bits SHALL pass unmodified; the block does no arithmetic or extension.

Reset
REQ-027 While rst=1: state EMPTY, out_valid=0, in_ready=0, out_payload=0, stall_cnt=0, taking effect without a clock edge.
REQ-028 First rising clk edge after rst falls SHALL set in_ready=1; no payload is accepted in the reset cycle.
REQ-029 rst asserted mid-operation SHALL discard all held entries immediately.

Verification
REQ-030 Reset then in_valid=1 with pc=0x00400000, imm_ext=0xFFFF8000, out_ready=1 -> out_valid=1 next cycle with identical payload; in_ready stays 1.
REQ-031 Stream A,B,C back-to-back with out_ready=0 -> A in main, B in skid, in_ready=0 after B, C held upstream; out_ready=1 then yields A,B,C in order over 3 cycles.
REQ-032 FULL state, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, ctrl=0, in_ready=1; neither held nor incoming payload appears.
REQ-033 out_valid=1, out_ready=0 held for 70000 cycles -> stall_cnt reads 16'hFFFF and stays; flush leaves it unchanged; rst returns it to 0.
REQ-034 rst asserted asynchronously between edges while FULL -> out_valid, in_ready, stall_cnt drop to 0 before the next edge.
REQ-035 Random in_valid/out_ready/flush (10k cycles) against a queue model -> output sequence matches, ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register built as a 2-entry in-order skid buffer.
// The main entry drives the EX stage. The skid entry catches one extra
// payload when EX stalls, so in_ready can be a registered output.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// valid must not depend on ready in the same cycle. The payload is only
// meaningful while valid is 1.
module id_ex_reg #(
   parameter  int WIDTH = 32,
   localparam int PW    = 5*WIDTH+25
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_payload,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_payload,
   output logic [15:0]   stall_cnt,
   output logic [1:0]    dbg_state
);

   // The encoding equals the number of held entries.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_in_ready;
   logic [PW-1:0]   r_main;
   logic [PW-1:0]   r_skid;
   logic [15:0]     r_stall_cnt;

   logic            w_out_valid;
   logic            w_accept;
   logic            w_pop;
   logic            w_load_main_in;
   logic            w_load_main_skid;
   logic            w_load_skid;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_accept    = in_valid & r_in_ready;
   assign w_pop       = w_out_valid & out_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_next;
   end

   // Next-state logic and entry load selects. A flush overrides everything else.
   always_comb begin
      w_next           = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_next         = ST_ONE;
               w_load_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && w_pop) begin
               w_load_main_in = 1'b1;
            end else if (w_pop) begin
               w_next = ST_EMPTY;
            end else if (w_accept) begin
               w_next      = ST_FULL;
               w_load_skid = 1'b1;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_next           = ST_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_next = ST_EMPTY;
      endcase
      if (flush) begin
         w_next           = ST_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   // in_ready is registered. It is low during reset and rises on the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_in_ready <= 1'b0;
      else     r_in_ready <= (w_next != ST_FULL);
   end

   // Main entry: the new payload or the skid entry moving forward.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_main <= '0;
      else if (w_load_main_in)   r_main <= in_payload;
      else if (w_load_main_skid) r_main <= r_skid;
   end

   // Skid entry: catches a payload while EX is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              r_skid <= '0;
      else if (w_load_skid) r_skid <= in_payload;
   end

   // Stall counter. It saturates at all-ones and a flush does not clear it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   // The bubble drives all zeros, so ctrl is zero whenever out_valid is low.
   assign out_payload = w_out_valid ? r_main : '0;
   assign out_valid   = w_out_valid;
   assign in_ready    = r_in_ready;
   assign stall_cnt   = r_stall_cnt;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed and random bench for id_ex_reg with a queue scoreboard.
module tb_id_ex_reg;

   localparam int WIDTH = 32;
   localparam int PW    = 5*WIDTH+25;

   // clock / reset
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_payload = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] out_payload;
   logic [15:0]   stall_cnt;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   id_ex_reg #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
      .stall_cnt(stall_cnt), .dbg_state(dbg_state)
   );

   // scoreboard
   logic [PW-1:0] exp_q[$];
   logic          m_rdy = 1'b0;
   logic [15:0]   m_stall = '0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
      chk("in_ready", 256'(in_ready), 256'(m_rdy));
      chk("stall_cnt", 256'(stall_cnt), 256'(m_stall));
      chk("state", 256'(dbg_state), 256'(exp_q.size()));
      if (exp_q.size() != 0) chk("payload", 256'(out_payload), 256'(exp_q[0]));
      else                   chk("bubble_ctrl", 256'(out_payload[9:0]), 256'(0));
   endtask

   function automatic logic [PW-1:0] mk(input logic [31:0] pc, input logic [31:0] imm,
                                       input logic [9:0] ctrl, input logic [7:0] tag);
      return {pc, {24'h0, tag}, ~{24'h0, tag}, imm, {27'h0, tag[4:0]},
              tag[4:0], 5'd2, 5'd3, ctrl};
   endfunction

   function automatic logic [PW-1:0] rp();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[PW-1:0];
   endfunction

   // driver: one cycle of stimulus with the model updated after the edge
   task automatic step(input logic iv, input logic [PW-1:0] pl, input logic ordy, input logic fl);
      logic acc, pop, vld;
      @(negedge clk);
      check_outputs();
      in_valid = iv; in_payload = pl; out_ready = ordy; flush = fl;
      vld = (exp_q.size() != 0);
      acc = iv & m_rdy;
      pop = vld & ordy;
      @(posedge clk);
      #1;
      if (vld && !ordy && m_stall != 16'hFFFF) m_stall++;
      if (fl) exp_q.delete();
      else begin
         if (pop) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(pl);
      end
      m_rdy = (exp_q.size() < 2);
   endtask

   // Reset is asserted between edges and checked before the next edge.
   task automatic async_reset();
      @(posedge clk);
      #2;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_stall", 256'(stall_cnt), 256'(0));
      chk("rst_payload", 256'(out_payload), 256'(0));
      exp_q.delete(); m_rdy = 1'b0; m_stall = '0;
   endtask

   // Release reset with a payload offered. It must not be taken in this cycle.
   task automatic release_reset(input logic [PW-1:0] pl);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; in_payload = pl; out_ready = 1'b1;
      chk("rel_in_ready", 256'(in_ready), 256'(0));
      @(posedge clk);
      #1;
      m_rdy = 1'b1;
   endtask

   logic [PW-1:0] pa, pb, pc_, pd;

   initial begin
      pa  = mk(32'h0040_0000, 32'hFFFF_8000, 10'h2A5, 8'h11);
      pb  = mk(32'h0040_0004, 32'h0000_7FFF, 10'h3FF, 8'h22);
      pc_ = mk(32'h0040_0008, 32'h0000_0001, 10'h001, 8'h33);
      pd  = mk(32'h0040_000C, 32'h1234_5678, 10'h155, 8'h44);

      // power-on reset holds the outputs at zero without any edge
      #1;
      chk("por_out_valid", 256'(out_valid), 256'(0));
      chk("por_in_ready", 256'(in_ready), 256'(0));
      chk("por_payload", 256'(out_payload), 256'(0));
      chk("por_stall", 256'(stall_cnt), 256'(0));
      repeat (2) @(posedge clk);
      release_reset(pd);

      // single transfer, latency 1
      step(1'b1, pa, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // A,B into main/skid, C held back, then drain in order
      step(1'b1, pa, 1'b0, 1'b0);
      step(1'b1, pb, 1'b0, 1'b0);
      step(1'b1, pc_, 1'b0, 1'b0);
      step(1'b1, pc_, 1'b1, 1'b0);
      step(1'b1, pc_, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // sustained stream with no bubbles
      for (int i = 0; i < 8; i++) step(1'b1, rp(), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // flush while FULL with accept and pop requested in the same cycle
      step(1'b1, pa, 1'b0, 1'b0);
      step(1'b1, pb, 1'b0, 1'b0);
      step(1'b1, pd, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);

      // long stall saturates the counter; flush keeps it; reset clears it
      step(1'b1, pa, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      m_stall = 16'hFFFF;
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b1, pb, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      async_reset();
      release_reset(pa);
      step(1'b0, '0, 1'b1, 1'b0);

      // asynchronous reset while FULL
      step(1'b1, pa, 1'b0, 1'b0);
      step(1'b1, pb, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      async_reset();
      release_reset(pc_);
      step(1'b0, '0, 1'b1, 1'b0);

      // random traffic against the queue model
      for (int i = 0; i < 10000; i++)
         step(1'($urandom_range(0, 1)), rp(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0));
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
